// File: rtl/cpu_control_pkg.sv
// Shared encodings for the multicycle CPU controller: states, op/ext codes, ALU and select codes.
// Latency: none (declarations only).
// Backpressure: none.
package cpu_control_pkg;

  // Controller states; HALT is only reachable when illegal-instruction halting is compiled in
  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    INCPC     = 3'd1,
    EXECUTE   = 3'd2,
    WRITEBACK = 3'd3,
    HALT      = 3'd4
  } state_e;

  // op field value that selects the register form; ext then carries the operation
  localparam logic [3:0] OP_REG   = 4'b0000;

  // Operation codes, shared by ext (register form) and op (immediate form)
  localparam logic [3:0] CODE_NOP = 4'b0000;
  localparam logic [3:0] CODE_AND = 4'b0001;
  localparam logic [3:0] CODE_OR  = 4'b0010;
  localparam logic [3:0] CODE_XOR = 4'b0011;
  localparam logic [3:0] CODE_ADD = 4'b0101;
  localparam logic [3:0] CODE_SUB = 4'b1001;
  localparam logic [3:0] CODE_CMP = 4'b1011;
  localparam logic [3:0] CODE_MOV = 4'b1101;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_CMP = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  // ALU operand selects
  localparam logic [1:0] ASEL_PC       = 2'b00;
  localparam logic [1:0] ASEL_SRC      = 2'b01;
  localparam logic [1:0] ASEL_IMM_SEXT = 2'b10;
  localparam logic [1:0] ASEL_IMM_ZEXT = 2'b11;
  localparam logic       BSEL_DEST     = 1'b0;
  localparam logic       BSEL_ONE      = 1'b1;

  // Register-file write-data selects
  localparam logic [1:0] WSEL_ALU      = 2'b00;
  localparam logic [1:0] WSEL_SRC      = 2'b01;
  localparam logic [1:0] WSEL_IMM_ZEXT = 2'b10;

  // Operation classes seen by the FSM
  typedef enum logic [2:0] {
    CLS_ALU     = 3'd0,
    CLS_ALU_IMM = 3'd1,
    CLS_MOV     = 3'd2,
    CLS_MOVI    = 3'd3,
    CLS_NOP     = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  typedef struct packed {
    op_class_e  op_class;
    logic [2:0] alu_op;
    logic       imm_zext;  // logical immediates zero-extend, arithmetic ones sign-extend
  } decode_t;

  // Arithmetic ops update the status flags; logical ops leave them alone
  function automatic logic sets_status(input logic [2:0] alu_op);
    return (alu_op == ALU_ADD) || (alu_op == ALU_SUB) || (alu_op == ALU_CMP);
  endfunction

endpackage

// File: rtl/instruction_decoder.sv
// Maps the instruction register to an operation class, ALU op and immediate-extension choice.
// Latency: purely combinational.
// Backpressure: none.
module instruction_decoder
  import cpu_control_pkg::*;
(
  input  logic [15:0] instruction,
  output decode_t     decode
);

  logic [3:0] op;
  logic [3:0] ext;
  logic       is_reg;
  logic [3:0] code;
  logic       unused_fields;

  assign op     = instruction[15:12];
  assign ext    = instruction[7:4];
  assign is_reg = (op == OP_REG);
  // Register and immediate forms share one code space, just carried in different fields
  assign code   = is_reg ? ext : op;
  // Register numbers and immediate bits are datapath business, not control
  assign unused_fields = ^{instruction[11:8], instruction[3:0]};

  // Classify the instruction and pick its ALU operation
  always_comb begin
    decode.op_class = CLS_ILLEGAL;
    decode.alu_op   = ALU_ADD;
    decode.imm_zext = 1'b0;
    case (code)
      CODE_ADD: begin
        decode.op_class = is_reg ? CLS_ALU : CLS_ALU_IMM;
        decode.alu_op   = ALU_ADD;
      end
      CODE_SUB: begin
        decode.op_class = is_reg ? CLS_ALU : CLS_ALU_IMM;
        decode.alu_op   = ALU_SUB;
      end
      CODE_CMP: begin
        decode.op_class = is_reg ? CLS_ALU : CLS_ALU_IMM;
        decode.alu_op   = ALU_CMP;
      end
      CODE_AND: begin
        decode.op_class = is_reg ? CLS_ALU : CLS_ALU_IMM;
        decode.alu_op   = ALU_AND;
        decode.imm_zext = 1'b1;
      end
      CODE_OR: begin
        decode.op_class = is_reg ? CLS_ALU : CLS_ALU_IMM;
        decode.alu_op   = ALU_OR;
        decode.imm_zext = 1'b1;
      end
      CODE_XOR: begin
        decode.op_class = is_reg ? CLS_ALU : CLS_ALU_IMM;
        decode.alu_op   = ALU_XOR;
        decode.imm_zext = 1'b1;
      end
      CODE_MOV: decode.op_class = is_reg ? CLS_MOV : CLS_MOVI;
      // code 0000 can only come from the register form (op=0000, ext=0000)
      CODE_NOP: decode.op_class = CLS_NOP;
      default:  decode.op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM (FETCH/INCPC/EXECUTE/WRITEBACK) driving every datapath select and enable.
// Latency: 3-4 cycles per instruction with memory_ready high; FETCH stretches while memory_ready is low.
// Backpressure: memory_ready low holds FETCH; CONTROLLER_ILLEGAL_HALT_EN makes illegal ops halt until reset.
module multicycle_controller
  import cpu_control_pkg::*;
#(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [15:0]            instruction,
  input  logic                   memory_ready,
  output logic                   memory_read_request,
  output logic [1:0]             alu_a_select,
  output logic                   alu_b_select,
  output logic [2:0]             alu_operation,
  output logic                   program_counter_write_enable,
  output logic                   status_write_enable,
  output logic                   instruction_write_enable,
  output logic                   register_write_enable,
  output logic [1:0]             register_write_data_select,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired_count
);

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] retired_q, retired_d;
  logic                   retire;
  decode_t                dec;

  instruction_decoder u_decoder (
    .instruction (instruction),
    .decode      (dec)
  );

  // State and retired counter; reset abandons any instruction in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // Next state; retire marks a return to FETCH that completes an instruction
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      FETCH: if (memory_ready) state_d = INCPC;
      INCPC: state_d = EXECUTE;
      EXECUTE: begin
        case (dec.op_class)
          CLS_ALU, CLS_ALU_IMM: begin
            if (dec.alu_op == ALU_CMP) begin
              state_d = FETCH;
              retire  = 1'b1;
            end else begin
              state_d = WRITEBACK;
            end
          end
          CLS_ILLEGAL: begin
`ifdef CONTROLLER_ILLEGAL_HALT_EN
            state_d = HALT;
`else
            state_d = FETCH;
            retire  = 1'b1;
`endif
          end
          default: begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        endcase
      end
      WRITEBACK: begin
        state_d = FETCH;
        retire  = 1'b1;
      end
`ifdef CONTROLLER_ILLEGAL_HALT_EN
      HALT: state_d = HALT;
`endif
      default: state_d = FETCH;
    endcase
  end

  assign retired_d     = retire ? retired_q + COUNT_ONE : retired_q;
  assign retired_count = retired_q;

  // Moore outputs from state plus decode; everything is forced low while reset is held
  always_comb begin
    memory_read_request          = 1'b0;
    alu_a_select                 = ASEL_PC;
    alu_b_select                 = BSEL_DEST;
    alu_operation                = ALU_ADD;
    program_counter_write_enable = 1'b0;
    status_write_enable          = 1'b0;
    instruction_write_enable     = 1'b0;
    register_write_enable        = 1'b0;
    register_write_data_select   = WSEL_ALU;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          memory_read_request      = 1'b1;
          instruction_write_enable = memory_ready;
        end
        INCPC: begin
          alu_a_select                 = ASEL_PC;
          alu_b_select                 = BSEL_ONE;
          alu_operation                = ALU_ADD;
          program_counter_write_enable = 1'b1;
        end
        EXECUTE: begin
          case (dec.op_class)
            CLS_ALU: begin
              alu_a_select        = ASEL_SRC;
              alu_operation       = dec.alu_op;
              status_write_enable = sets_status(dec.alu_op);
            end
            CLS_ALU_IMM: begin
              alu_a_select        = dec.imm_zext ? ASEL_IMM_ZEXT : ASEL_IMM_SEXT;
              alu_operation       = dec.alu_op;
              status_write_enable = sets_status(dec.alu_op);
            end
            CLS_MOV: begin
              register_write_enable      = 1'b1;
              register_write_data_select = WSEL_SRC;
            end
            CLS_MOVI: begin
              register_write_enable      = 1'b1;
              register_write_data_select = WSEL_IMM_ZEXT;
            end
            default: ;
          endcase
        end
        WRITEBACK: begin
          register_write_enable      = 1'b1;
          register_write_data_select = WSEL_ALU;
        end
        default: ;
      endcase
    end
  end

`ifdef CONTROLLER_ILLEGAL_HALT_EN
  assign halted = !reset && (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
